// File: rtl/jt1943_pkg.sv
// Shared types and defaults for the 1943 ROM download path.
package jt1943_pkg;

  localparam logic [21:0] PROM_START_DEF = 22'h1F_0000;
  localparam int          PROM_NUM_DEF   = 12;

  localparam logic [1:0] MASK_NONE = 2'b11;
  localparam logic [1:0] MASK_EVEN = 2'b10;
  localparam logic [1:0] MASK_ODD  = 2'b01;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } prog_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Byte lanes are disabled active-high: keep the lane that the byte belongs to.
  function automatic logic [1:0] lane_mask(input logic addr_lsb);
    return addr_lsb ? MASK_ODD : MASK_EVEN;
  endfunction

endpackage

// File: rtl/jt1943_prog_loader_fifo.sv
// Two-entry FIFO of {addr, data} download bytes; full/empty come from a registered count.
module jtframe_fifo2
  import jt1943_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  prog_entry_t din,
  input  logic        pop,
  output prog_entry_t dout,
  output logic        full,
  output logic        empty
);

  prog_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt1943_prog_loader.sv
// Splits the ioctl download stream into SDRAM write requests and on-chip PROM load strobes.
module jt1943_prog_loader
  import jt1943_pkg::*;
#(
  parameter logic [21:0] PROM_START = PROM_START_DEF,
  parameter int          PROM_NUM   = PROM_NUM_DEF,
  parameter logic [21:0] SDRAM_OFF  = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_ack,
  output logic [PROM_NUM-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic [7:0]          prom_data,
  output logic                load_done,
  output logic                overflow
);

  localparam logic [PROM_NUM-1:0] PROM_ONE = {{(PROM_NUM-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic                wr_valid;
  logic                in_prom;
  logic [13:0]         prom_idx;
  logic                prom_hit;
  logic [PROM_NUM-1:0] prom_we_next;
  logic                push_req;
  logic                issue;
  logic                release_req;
  logic                fifo_full;
  logic                fifo_empty;
  prog_entry_t         fifo_head;
  prog_entry_t         fifo_in;
  logic                dl_d;
  logic                done_latch;
  logic                done_cond;

  // Address decode: SDRAM bytes go to the FIFO, PROM bytes become a one-hot strobe.
  always_comb begin
    wr_valid = downloading & ioctl_wr;
    in_prom  = (ioctl_addr >= PROM_START);
    prom_idx = 14'((ioctl_addr - PROM_START) >> 8);
    push_req = wr_valid & ~in_prom;
    prom_hit = wr_valid & in_prom & (prom_idx < 14'(PROM_NUM));
    fifo_in  = '{addr: ioctl_addr, data: ioctl_data};
    if (prom_hit) begin
      prom_we_next = PROM_ONE << prom_idx;
    end else begin
      prom_we_next = '0;
    end
  end

  jtframe_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (fifo_in),
    .pop   (issue),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) next_state = ST_WAIT;
        else             next_state = ST_IDLE;
      end
      ST_WAIT: begin
        if (prog_ack) next_state = ST_IDLE;
        else          next_state = ST_WAIT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM actions; ack outside WAIT is ignored
  always_comb begin
    issue       = 1'b0;
    release_req = 1'b0;
    case (state)
      ST_IDLE: issue       = ~fifo_empty;
      ST_WAIT: release_req = prog_ack;
      default: begin
        issue       = 1'b0;
        release_req = 1'b0;
      end
    endcase
  end

  // SDRAM request registers, held stable while waiting for ack
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_addr <= 22'h0;
      prog_data <= 8'h00;
      prog_mask <= MASK_NONE;
      prog_we   <= 1'b0;
    end else if (issue) begin
      prog_addr <= (fifo_head.addr >> 1) + SDRAM_OFF;
      prog_data <= fifo_head.data;
      prog_mask <= lane_mask(fifo_head.addr[0]);
      prog_we   <= 1'b1;
    end else if (release_req) begin
      prog_we   <= 1'b0;
      prog_mask <= MASK_NONE;
    end
  end

  // PROM strobe and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we   <= '0;
      prom_addr <= 8'h00;
      prom_data <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      prom_we <= prom_we_next;
      if (prom_hit) begin
        prom_addr <= ioctl_addr[7:0];
        prom_data <= ioctl_data;
      end
      if (push_req && fifo_full && !issue) begin
        overflow <= 1'b1;
      end
    end
  end

  // Done fires as the last request is acked (or right away if nothing is queued).
  always_comb begin
    done_cond = done_latch & fifo_empty & ~push_req & ~issue & (next_state == ST_IDLE);
  end

  // Download-end latch and load_done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_d       <= 1'b0;
      done_latch <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      dl_d      <= downloading;
      load_done <= done_cond;
      if (dl_d && !downloading) begin
        done_latch <= 1'b1;
      end else if (done_cond) begin
        done_latch <= 1'b0;
      end
    end
  end

endmodule
